// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO GPIO controller: IO region select bit,
// register indices and a constant-width helper.
package mmio_pkg;

  localparam int          IO_SEL_BIT   = 13;
  localparam logic [3:0]  REG_IN_STATE = 4'd0;
  localparam logic [3:0]  REG_OUT      = 4'd1;
  localparam logic [3:0]  REG_EDGE     = 4'd2;
  localparam logic [3:0]  REG_TOGGLE   = 4'd3;

  // Ceiling log2; used only on elaboration-time constants.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input channel: 2-flop synchroniser, hold-time debouncer and a
// one-cycle rise pulse coincident with the stable 0->1 update.
module gpio_debounce
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic rise
);

  localparam int             CW       = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  assign sync   = sync_pipe[1];
  // The new level has been held long enough; stable flips this edge.
  assign accept = (sync != stable) && (cnt == CNT_TERM);
  assign rise   = accept & sync;

  // Synchroniser chain for the asynchronous button level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], btn};
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// CPU data-bus decoder: RAM below the IO select bit, a small GPIO register
// file above it (debounced inputs, LED latch, sticky edges, atomic toggle).
module mmio_gpio_ctrl
  import mmio_pkg::*;
#(
  parameter int N_IN            = 1,
  parameter int N_OUT           = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      address,
  input  logic             load,
  input  logic [15:0]      in,
  output logic [15:0]      out,
  output logic             ram_load,
  input  logic [15:0]      ram_out,
  input  logic [N_IN-1:0]  btn,
  output logic [N_OUT-1:0] led
);

  logic            io_sel;
  logic [3:0]      idx;
  logic            io_wr;
  logic [N_IN-1:0] in_state;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] edge_flags;
  logic [N_IN-1:0] w1c;
  logic [15:0]     io_rdata;
  logic            unused_bits;

  // Address bits [12:4] alias the register map; upper address bits are unused.
  assign io_sel      = address[IO_SEL_BIT];
  assign idx         = address[3:0];
  assign io_wr       = load & io_sel;
  assign ram_load    = load & ~io_sel;
  assign w1c         = (io_wr && idx == REG_EDGE) ? in[N_IN-1:0] : '0;
  assign unused_bits = ^{address[15:14], address[12:4], in};

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn[g]),
      .stable (in_state[g]),
      .rise   (rise[g])
    );
  end

  // Sticky rise flags; a same-cycle rise beats the write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) edge_flags <= '0;
    else     edge_flags <= (edge_flags & ~w1c) | rise;
  end

  // LED latch: direct write or atomic XOR toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            led <= '0;
    else if (io_wr && idx == REG_OUT)    led <= in[N_OUT-1:0];
    else if (io_wr && idx == REG_TOGGLE) led <= led ^ in[N_OUT-1:0];
  end

  // IO read mux over registered state only; unmapped and write-only read 0.
  always_comb begin
    io_rdata = '0;
    case (idx)
      REG_IN_STATE: io_rdata[N_IN-1:0]  = in_state;
      REG_OUT:      io_rdata[N_OUT-1:0] = led;
      REG_EDGE:     io_rdata[N_IN-1:0]  = edge_flags;
      default:      io_rdata = '0;
    endcase
  end

  assign out = io_sel ? io_rdata : ram_out;

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Directed bench for mmio_gpio_ctrl with a cycle-level behavioural model
// compared every negedge plus hand-computed literal checks.
module tb_mmio_gpio_ctrl;

  localparam int N_IN  = 2;
  localparam int N_OUT = 4;
  localparam int DC    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       address = '0;
  logic              load = 1'b0;
  logic [15:0]       in = '0;
  logic [15:0]       ram_out = '0;
  logic [N_IN-1:0]   btn = '0;
  wire  [15:0]       out;
  wire               ram_load;
  wire  [N_OUT-1:0]  led;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_gpio_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .load     (load),
    .in       (in),
    .out      (out),
    .ram_load (ram_load),
    .ram_out  (ram_out),
    .btn      (btn),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A level is accepted once the last DC synchronised samples all disagree
  // with the current accepted level; samples reach the debouncer 2 edges late.
  logic [N_IN-1:0]  hist[$];
  logic [DC-1:0]    win[N_IN];
  int               nv[N_IN];
  logic [N_IN-1:0]  m_stable, m_edge, m_smp, m_rise;
  logic [N_OUT-1:0] m_led;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      m_stable = '0;
      m_edge   = '0;
      m_led    = '0;
      for (int i = 0; i < N_IN; i++) begin
        nv[i]  = 0;
        win[i] = '0;
      end
    end else begin
      m_smp = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      hist.push_back(btn);
      if (hist.size() > 2) void'(hist.pop_front());
      m_rise = '0;
      if (load && address[13]) begin
        case (address[3:0])
          4'd1: m_led = in[N_OUT-1:0];
          4'd2: m_edge = m_edge & ~in[N_IN-1:0];
          4'd3: m_led = m_led ^ in[N_OUT-1:0];
          default: ;
        endcase
      end
      for (int i = 0; i < N_IN; i++) begin
        win[i] = {win[i][DC-2:0], m_smp[i]};
        if (nv[i] < DC) nv[i]++;
        if (nv[i] == DC && win[i] == {DC{~m_stable[i]}}) begin
          m_stable[i] = ~m_stable[i];
          if (m_stable[i]) m_rise[i] = 1'b1;
        end
      end
      m_edge = m_edge | m_rise;
    end
  end

  function automatic logic [15:0] exp_out();
    logic [15:0] r;
    r = '0;
    if (!address[13]) r = ram_out;
    else case (address[3:0])
      4'd0: r[N_IN-1:0]  = m_stable;
      4'd1: r[N_OUT-1:0] = m_led;
      4'd2: r[N_IN-1:0]  = m_edge;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Continuous compare against the model away from the active edge.
  always @(negedge clk) begin
    check("model_out", out, exp_out());
    check("model_ram_load", {15'b0, ram_load}, {15'b0, load & ~address[13]});
    check("model_led", 16'(led), 16'(m_led));
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [15:0] a);
    address = a;
    load    = 1'b0;
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    rd(16'h2000); check("rst_in_state", out, 16'h0000);
    rd(16'h2001); check("rst_out", out, 16'h0000);
    rd(16'h2002); check("rst_edge", out, 16'h0000);
    check("rst_led", 16'(led), 16'h0000);

    // RAM pass-through
    address = 16'h0005; in = 16'h1234; load = 1'b1; ram_out = 16'hBEEF; #1;
    check("ram_load_hi", {15'b0, ram_load}, 16'h0001);
    check("ram_rdata", out, 16'hBEEF);
    address = 16'h2005; #1;
    check("ram_load_io", {15'b0, ram_load}, 16'h0000);
    step(1);
    load = 1'b0;

    // Glitch of 3 cycles is rejected
    btn[1] = 1'b1;
    step(3);
    btn[1] = 1'b0;
    step(8);
    rd(16'h2000); check("glitch_in_state", out, 16'h0000);
    rd(16'h2002); check("glitch_edge", out, 16'h0000);

    // Held level accepted exactly 2+DC edges after the change
    btn[1] = 1'b1;
    step(5);
    rd(16'h2000); check("accept_early", out, 16'h0000);
    step(1);
    rd(16'h2000); check("accept_in_state", out, 16'h0002);
    rd(16'h2002); check("accept_edge", out, 16'h0002);

    // W1C
    address = 16'h2002; in = 16'h0002; load = 1'b1;
    step(1);
    rd(16'h2002); check("w1c_clear", out, 16'h0000);

    // Falling acceptance does not set EDGE; then collide a rise with W1C
    btn[1] = 1'b0;
    step(8);
    rd(16'h2000); check("fall_in_state", out, 16'h0000);
    rd(16'h2002); check("fall_no_edge", out, 16'h0000);
    btn[1] = 1'b1;
    step(5);
    address = 16'h2002; in = 16'h0002; load = 1'b1;
    step(1);
    rd(16'h2002); check("collide_edge", out, 16'h0002);
    rd(16'h2000); check("collide_in_state", out, 16'h0002);

    // Writing 0 to a flag bit leaves it set
    address = 16'h2002; in = 16'hFFFD; load = 1'b1;
    step(1);
    rd(16'h2002); check("w0_no_effect", out, 16'h0002);

    // LED write / toggle / write-only read
    address = 16'h2001; in = 16'hFFF5; load = 1'b1;
    step(1);
    load = 1'b0;
    check("led_write", 16'(led), 16'h0005);
    rd(16'h2001); check("led_readback", out, 16'h0005);
    address = 16'h2003; in = 16'h000F; load = 1'b1;
    step(1);
    load = 1'b0;
    check("led_toggle", 16'(led), 16'h000A);
    rd(16'h2003); check("toggle_reads0", out, 16'h0000);

    // Aliased address
    address = 16'h2FF1; in = 16'h0003; load = 1'b1;
    step(1);
    load = 1'b0;
    check("alias_led", 16'(led), 16'h0003);

    // Async reset between edges; held button re-accepted as a rise afterwards
    rst = 1'b1;
    #1;
    check("async_rst_led", 16'(led), 16'h0000);
    step(1);
    rst = 1'b0;
    step(5);
    rd(16'h2000); check("post_rst_early", out, 16'h0000);
    step(1);
    rd(16'h2000); check("post_rst_in_state", out, 16'h0002);
    rd(16'h2002); check("post_rst_edge", out, 16'h0002);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
